// File: rtl/gf16_pkg.sv
// Shared GF(16) definitions for the RS(15,9) encoder/decoder chain:
// code constants, field polynomial, root table, general multiply and FSM states.
package gf16_pkg;

    localparam int N    = 15;
    localparam int K    = 9;
    localparam int NSYM = 6;

    // x^4 + x + 1
    localparam logic [4:0] PRIM_POLY = 5'h13;

    // alpha^1..alpha^6, root j at bits [4(j-1)+3:4(j-1)]
    localparam logic [NSYM*4-1:0] ALPHA_TABLE = 24'hC63842;

    // General GF(16) multiply: shift-and-add with reduction after each doubling.
    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] prod;
        logic [3:0] x;
        prod = 4'h0;
        x    = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) prod = prod ^ x;
            x = {x[2:0], 1'b0} ^ ({4{x[3]}} & PRIM_POLY[3:0]);
        end
        return prod;
    endfunction

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ACCUM = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/rs_syndrome_cell.sv
// One syndrome lane: Horner accumulator acc <- acc*alpha^j xor symbol.
// acc_next exposes the value the accumulator takes on the current edge so the
// top level can latch the final syndrome on the same edge as the last symbol.
module rs_syndrome_cell
    import gf16_pkg::*;
#(
    parameter logic [3:0] ALPHA = 4'h2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       enable,
    input  logic [3:0] sym,
    output logic [3:0] acc_next
);

    logic [3:0] acc;

    // ALPHA is a constant, so this folds to a few XOR gates
    assign acc_next = gf_mul(acc, ALPHA) ^ sym;

    // Accumulator: cleared on capture, advanced once per symbol
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= 4'h0;
        end else if (clear) begin
            acc <= 4'h0;
        end else if (enable) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/rs_syndrome_calc.sv
// RS(15,9) syndrome calculator: captures a 60-bit word, feeds symbols 14..0
// into six parallel Horner lanes (roots alpha^1..alpha^6) and publishes the
// six syndromes plus an any-nonzero flag.
module rs_syndrome_calc
    import gf16_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [59:0] codeWordIn,
    input  logic        decodeStart,
    output logic        decoderBusy,
    output logic        syndromeValid,
    output logic [23:0] syndromeOut,
    output logic        errorDetected
);

    state_t      state;
    logic [3:0]  cnt;
    logic [59:0] cw;
    logic [63:0] cw_ext;
    logic [3:0]  sym;
    logic        start;
    logic        accum;
    logic        last;
    logic [23:0] syn_next;

    assign start = (state == ST_IDLE) && decodeStart;
    assign accum = (state == ST_ACCUM);
    assign last  = accum && (cnt == 4'd0);

    // Padded to 64 bits so every 4-bit counter value selects in range
    assign cw_ext = {4'h0, cw};
    assign sym    = cw_ext[{cnt, 2'b00} +: 4];

    for (genvar j = 0; j < NSYM; j++) begin : g_cell
        rs_syndrome_cell #(
            .ALPHA (ALPHA_TABLE[4*j +: 4])
        ) u_cell (
            .clk      (clk),
            .rst_n    (rst_n),
            .clear    (start),
            .enable   (accum),
            .sym      (sym),
            .acc_next (syn_next[4*j +: 4])
        );
    end

    // Control FSM and symbol counter (highest-order symbol first)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (decodeStart) begin
                        state <= ST_ACCUM;
                        cnt   <= 4'(N - 1);
                    end
                end
                ST_ACCUM: begin
                    if (cnt == 4'd0) state <= ST_DONE;
                    else             cnt   <= cnt - 4'd1;
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Capture register: the input word is only needed on the start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     cw <= 60'h0;
        else if (start) cw <= codeWordIn;
    end

    // Result registers: loaded with the lane values produced by symbol 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syndromeOut   <= 24'h0;
            errorDetected <= 1'b0;
        end else if (last) begin
            syndromeOut   <= syn_next;
            errorDetected <= |syn_next;
        end
    end

    assign decoderBusy   = (state != ST_IDLE);
    assign syndromeValid = (state == ST_DONE);

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Self-checking bench for rs_syndrome_calc: fixed vectors, timing sequences
// and randomised encoder codewords with injected symbol errors.
module tb_rs_syndrome_calc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [59:0] codeWordIn = 60'h0;
    logic        decodeStart = 1'b0;
    logic        decoderBusy;
    logic        syndromeValid;
    logic [23:0] syndromeOut;
    logic        errorDetected;

    rs_syndrome_calc dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .codeWordIn    (codeWordIn),
        .decodeStart   (decodeStart),
        .decoderBusy   (decoderBusy),
        .syndromeValid (syndromeValid),
        .syndromeOut   (syndromeOut),
        .errorDetected (errorDetected)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // GF(16) exp/log tables and generator polynomial of the reference model
    int gexp [15];
    int glog [16];
    int gen  [7];

    typedef struct {
        logic [59:0] cw;
        logic [23:0] synd;
        logic        err;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return gexp[(glog[a] + glog[b]) % 15];
    endfunction

    // S_j = sum over i of r_i * alpha^(i*j), evaluated with log tables
    function automatic logic [23:0] model(input logic [59:0] w);
        logic [23:0] s;
        s = 24'h0;
        for (int j = 1; j <= 6; j++) begin
            int acc;
            acc = 0;
            for (int i = 0; i < 15; i++) begin
                int r;
                r = int'(w[4*i +: 4]);
                if (r != 0) acc = acc ^ gexp[(glog[r] + i*j) % 15];
            end
            s[4*(j-1) +: 4] = 4'(acc);
        end
        return s;
    endfunction

    // Systematic encoder: parity = msg(x)*x^6 mod g(x)
    function automatic logic [59:0] encode(input logic [35:0] msg);
        int b [6];
        logic [59:0] w;
        for (int k = 0; k < 6; k++) b[k] = 0;
        for (int i = 8; i >= 0; i--) begin
            int fb;
            fb = int'(msg[4*i +: 4]) ^ b[5];
            for (int k = 5; k >= 1; k--) b[k] = b[k-1] ^ gmul(fb, gen[k]);
            b[0] = gmul(fb, gen[0]);
        end
        w[59:24] = msg;
        for (int k = 0; k < 6; k++) w[4*k +: 4] = 4'(b[k]);
        return w;
    endfunction

    // Waits (bounded) for the valid pulse; lat=0 means it never came
    task automatic wait_result(output int lat, output bit stable, input logic [23:0] prev);
        lat = 0;
        stable = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (syndromeValid) begin
                lat = k;
                break;
            end
            if (syndromeOut !== prev) stable = 1'b0;
        end
    endtask

    task automatic run_word(input logic [59:0] w, input logic [23:0] exp_s,
                            input logic exp_e, input string tag);
        logic [23:0] prev;
        int lat;
        bit stable;
        @(negedge clk);
        codeWordIn  = w;
        decodeStart = 1'b1;
        prev = syndromeOut;
        @(negedge clk);
        decodeStart = 1'b0;
        codeWordIn  = 60'({$urandom(), $urandom()});
        chk({tag, ".busy_rise"}, 64'(decoderBusy), 64'(1));
        wait_result(lat, stable, prev);
        chk({tag, ".latency"}, 64'(lat), 64'(15));
        chk({tag, ".hold"}, 64'(stable), 64'(1));
        chk({tag, ".synd"}, 64'(syndromeOut), 64'(exp_s));
        chk({tag, ".err"}, 64'(errorDetected), 64'(exp_e));
        @(negedge clk);
        chk({tag, ".valid_drop"}, 64'(syndromeValid), 64'(0));
        chk({tag, ".busy_fall"}, 64'(decoderBusy), 64'(0));
    endtask

    initial begin
        int v;
        int lat;
        bit stable;

        v = 1;
        for (int k = 0; k < 15; k++) begin
            gexp[k] = v;
            glog[v] = k;
            v = v * 2;
            if (v > 15) v = v ^ 19;
        end
        glog[0] = 0;
        gen[0] = 1;
        for (int k = 1; k < 7; k++) gen[k] = 0;
        for (int j = 1; j <= 6; j++) begin
            for (int k = j; k >= 1; k--) gen[k] = gen[k-1] ^ gmul(gen[k], gexp[j]);
            gen[0] = gmul(gen[0], gexp[j]);
        end

        vecs[0] = '{60'h0,               24'h000000, 1'b0};
        vecs[1] = '{60'h000000001793CAC, 24'h000000, 1'b0};
        vecs[2] = '{60'h1,               24'h111111, 1'b1};
        vecs[3] = '{60'h10,              24'hC63842, 1'b1};
        vecs[4] = '{60'h100,             24'hF75C34, 1'b1};
        vecs[5] = '{60'h100000000000000, 24'hA7EFD9, 1'b1};

        // Reset state, then release with decodeStart already high
        repeat (3) @(negedge clk);
        chk("rst.busy",  64'(decoderBusy),   64'(0));
        chk("rst.valid", 64'(syndromeValid), 64'(0));
        chk("rst.synd",  64'(syndromeOut),   64'(0));
        chk("rst.err",   64'(errorDetected), 64'(0));
        codeWordIn  = 60'h10;
        decodeStart = 1'b1;
        rst_n       = 1'b1;
        @(negedge clk);
        decodeStart = 1'b0;
        chk("rel.busy", 64'(decoderBusy), 64'(1));
        wait_result(lat, stable, 24'h0);
        chk("rel.latency", 64'(lat), 64'(15));
        chk("rel.synd", 64'(syndromeOut), 64'(24'hC63842));

        // Fixed vectors
        for (int i = 0; i < 6; i++)
            run_word(vecs[i].cw, vecs[i].synd, vecs[i].err, $sformatf("vec%0d", i));

        // decodeStart held high: second capture 17 cycles after the first,
        // and the input word may change freely after capture
        @(negedge clk);
        codeWordIn  = 60'h1;
        decodeStart = 1'b1;
        @(negedge clk);
        codeWordIn  = 60'h100;
        wait_result(lat, stable, syndromeOut);
        chk("b2b.lat1",  64'(lat), 64'(15));
        chk("b2b.synd1", 64'(syndromeOut), 64'(24'h111111));
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (syndromeValid) begin
                lat = k;
                break;
            end
        end
        decodeStart = 1'b0;
        chk("b2b.spacing", 64'(lat), 64'(17));
        chk("b2b.synd2", 64'(syndromeOut), 64'(24'hF75C34));
        @(negedge clk);
        chk("b2b.idle", 64'(decoderBusy), 64'(0));

        // Start pulses during ACCUM and DONE are ignored
        @(negedge clk);
        codeWordIn  = 60'h10;
        decodeStart = 1'b1;
        @(negedge clk);
        decodeStart = 1'b0;
        repeat (4) @(negedge clk);
        codeWordIn  = 60'h1;
        decodeStart = 1'b1;
        @(negedge clk);
        decodeStart = 1'b0;
        wait_result(lat, stable, syndromeOut);
        chk("ign.latency", 64'(lat), 64'(10));
        chk("ign.synd", 64'(syndromeOut), 64'(24'hC63842));
        decodeStart = 1'b1;
        @(negedge clk);
        decodeStart = 1'b0;
        chk("ign.done_busy", 64'(decoderBusy), 64'(0));
        repeat (2) @(negedge clk);
        chk("ign.still_idle", 64'(decoderBusy), 64'(0));
        chk("ign.synd_hold", 64'(syndromeOut), 64'(24'hC63842));

        // Asynchronous reset in the middle of accumulation
        run_word(60'h1, 24'h111111, 1'b1, "pre_abort");
        @(negedge clk);
        codeWordIn  = 60'h10;
        decodeStart = 1'b1;
        @(negedge clk);
        decodeStart = 1'b0;
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort.synd",  64'(syndromeOut),   64'(0));
        chk("abort.err",   64'(errorDetected), 64'(0));
        chk("abort.busy",  64'(decoderBusy),   64'(0));
        chk("abort.valid", 64'(syndromeValid), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_word(60'h100, 24'hF75C34, 1'b1, "post_abort");

        // Randomised encoder codewords with 0..3 distinct symbol errors
        for (int n = 0; n < 1000; n++) begin
            logic [35:0] msg;
            logic [59:0] errpat;
            logic [59:0] rx;
            logic [23:0] exp_s;
            logic [14:0] used;
            int nerr;
            msg    = {4'($urandom()), 32'($urandom())};
            errpat = 60'h0;
            used   = 15'h0;
            nerr   = int'($urandom_range(0, 3));
            for (int e = 0; e < nerr; e++) begin
                int pos;
                pos = int'($urandom_range(0, 14));
                while (used[pos]) pos = int'($urandom_range(0, 14));
                used[pos] = 1'b1;
                errpat[4*pos +: 4] = 4'($urandom_range(1, 15));
            end
            rx    = encode(msg) ^ errpat;
            exp_s = model(rx);
            run_word(rx, exp_s, |exp_s, "rand");
            if (errpat != 60'h0) chk("rand.detect", 64'(errorDetected), 64'(1));
            else                 chk("rand.clean",  64'(syndromeOut),   64'(0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
